// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the TX FIFO write-side arbiter: state encoding and requester IDs.
package fifo_wr_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  localparam logic REQ_RF  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-input round-robin grant; on a tie the requester not granted last time wins.
module fifo_wr_arbiter_rr_arb2
  import fifo_wr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_rf,
  input  logic req_alu,
  input  logic update,
  output logic grant_any_c,
  output logic grant_id_c
);

  logic last_grant_q;

  always_comb begin
    grant_any_c = req_rf | req_alu;
    if (req_rf && req_alu) begin
      grant_id_c = ~last_grant_q;
    end else if (req_alu) begin
      grant_id_c = REQ_ALU;
    end else begin
      grant_id_c = REQ_RF;
    end
  end

  // Reset to ALU so the first tie after reset goes to the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_ALU;
    end else if (update && grant_any_c) begin
      last_grant_q <= grant_id_c;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the TX FIFO write port between the RF byte path and the two-byte ALU result path.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic                    rf_valid,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic                    rf_ready,
  input  logic                    alu_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic                    busy
);

  localparam int unsigned HOLD_WIDTH = 2 * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_two_q, hold_two_d;
  logic                    grant_any_c;
  logic                    grant_id_c;
  logic                    in_idle_c;

  assign in_idle_c = (state_q == IDLE);

  fifo_wr_arbiter_rr_arb2 u_arb (
    .clk         (wclk),
    .rst_n       (wrst_n),
    .req_rf      (rf_valid),
    .req_alu     (alu_valid),
    .update      (in_idle_c),
    .grant_any_c (grant_any_c),
    .grant_id_c  (grant_id_c)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_two_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_two_q <= hold_two_d;
    end
  end

  // winc is left ungated by wfull: the FIFO masks it, so both sides count the same beats.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_two_d = hold_two_q;
    rf_ready   = 1'b0;
    alu_ready  = 1'b0;
    winc       = 1'b0;
    wdata      = '0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any_c) begin
          state_d = SEND_LO;
          if (grant_id_c == REQ_ALU) begin
            alu_ready  = 1'b1;
            hold_d     = alu_data;
            hold_two_d = 1'b1;
          end else begin
            rf_ready   = 1'b1;
            hold_d     = HOLD_WIDTH'(rf_data);
            hold_two_d = 1'b0;
          end
        end
      end
      SEND_LO: begin
        winc  = 1'b1;
        busy  = 1'b1;
        wdata = hold_q[DATA_WIDTH-1:0];
        if (!wfull) begin
          state_d = hold_two_q ? SEND_HI : IDLE;
        end
      end
      SEND_HI: begin
        winc  = 1'b1;
        busy  = 1'b1;
        wdata = hold_q[HOLD_WIDTH-1:DATA_WIDTH];
        if (!wfull) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based reference model checked every cycle plus directed byte-stream checks.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic            rf_valid;
  logic [DW-1:0]   rf_data;
  logic            rf_ready;
  logic            alu_valid;
  logic [2*DW-1:0] alu_data;
  logic            alu_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .rf_valid  (rf_valid),
    .rf_data   (rf_data),
    .rf_ready  (rf_ready),
    .alu_valid (alu_valid),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester queues: each head is presented with valid held until ready.
  logic [DW-1:0]   rf_pend[$];
  logic [2*DW-1:0] alu_pend[$];

  initial begin
    logic rh, ah;
    rf_valid  = 1'b0;
    rf_data   = '0;
    alu_valid = 1'b0;
    alu_data  = '0;
    forever begin
      @(posedge wclk);
      rh = rf_valid && rf_ready;
      ah = alu_valid && alu_ready;
      #1;
      if (rh) void'(rf_pend.pop_front());
      if (ah) void'(alu_pend.pop_front());
      rf_valid  = (rf_pend.size() != 0);
      rf_data   = rf_valid ? rf_pend[0] : '0;
      alu_valid = (alu_pend.size() != 0);
      alu_data  = alu_valid ? alu_pend[0] : '0;
    end
  end

  // Reference model: bytes still owed to the FIFO for the current transfer, and who won last.
  logic [DW-1:0] m_q[$];
  logic          m_last;
  logic [DW-1:0] wlog[$];
  int            rf_rdy_cnt  = 0;
  int            alu_rdy_cnt = 0;
  int            winc_cnt    = 0;

  always @(posedge wclk or negedge wrst_n) begin
    logic win;
    if (!wrst_n) begin
      m_q.delete();
      m_last <= 1'b1;
    end else begin
      if (m_q.size() == 0) begin
        if (rf_valid || alu_valid) begin
          win = (rf_valid && alu_valid) ? ~m_last : alu_valid;
          if (win) begin
            m_q.push_back(alu_data[DW-1:0]);
            m_q.push_back(alu_data[2*DW-1:DW]);
          end else begin
            m_q.push_back(rf_data);
          end
          m_last <= win;
        end
      end else if (!wfull) begin
        void'(m_q.pop_front());
      end
      if (winc && !wfull) wlog.push_back(wdata);
      if (winc) winc_cnt <= winc_cnt + 1;
      if (rf_valid && rf_ready) rf_rdy_cnt <= rf_rdy_cnt + 1;
      if (alu_valid && alu_ready) alu_rdy_cnt <= alu_rdy_cnt + 1;
    end
  end

  initial begin
    logic          e_busy, e_rf, e_alu;
    logic [DW-1:0] e_data;
    forever begin
      @(negedge wclk);
      e_busy = (m_q.size() != 0);
      e_data = e_busy ? m_q[0] : '0;
      e_rf   = !e_busy && rf_valid && (!alu_valid || m_last);
      e_alu  = !e_busy && alu_valid && (!rf_valid || !m_last);
      check("cyc_busy",      32'(busy),      32'(e_busy));
      check("cyc_winc",      32'(winc),      32'(e_busy));
      check("cyc_wdata",     32'(wdata),     32'(e_data));
      check("cyc_rf_ready",  32'(rf_ready),  32'(e_rf));
      check("cyc_alu_ready", 32'(alu_ready), 32'(e_alu));
    end
  end

  task automatic check_log(input string name, input int base, input logic [DW-1:0] exp[$]);
    check({name, "_len"}, 32'(wlog.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < wlog.size()) check({name, "_byte"}, 32'(wlog[base + i]), 32'(exp[i]));
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge wclk);
      #3;
      done = (rf_pend.size() == 0) && (alu_pend.size() == 0) && !rf_valid && !alu_valid && !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got busy expected idle within 200 cycles", name);
    end
  endtask

  task automatic step;
    @(posedge wclk);
    #2;
  endtask

  task automatic pulse_reset;
    step();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
  endtask

  initial begin
    int lb, rb, ab, wb;
    wrst_n = 1'b0;
    wfull  = 1'b0;
    @(negedge wclk);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_winc",  32'(winc),      32'd0);
    check("rst_wdata", 32'(wdata),     32'd0);
    check("rst_rfrdy", 32'(rf_ready),  32'd0);
    check("rst_alurdy",32'(alu_ready), 32'd0);
    step();
    wrst_n = 1'b1;

    // Single RF byte
    lb = wlog.size(); rb = rf_rdy_cnt; wb = winc_cnt;
    step(); rf_pend.push_back(8'hA5);
    wait_idle("t1");
    check("t1_rf_ready_cycles", 32'(rf_rdy_cnt - rb), 32'd1);
    check("t1_winc_cycles",     32'(winc_cnt - wb),   32'd1);
    check_log("t1", lb, '{8'hA5});

    // ALU pair, low byte first
    lb = wlog.size(); ab = alu_rdy_cnt; wb = winc_cnt;
    step(); alu_pend.push_back(16'h1234);
    wait_idle("t2");
    check("t2_alu_ready_cycles", 32'(alu_rdy_cnt - ab), 32'd1);
    check("t2_winc_cycles",      32'(winc_cnt - wb),    32'd2);
    check_log("t2", lb, '{8'h34, 8'h12});

    // Both pending from reset: RF, ALU, RF
    pulse_reset();
    lb = wlog.size();
    step(); rf_pend.push_back(8'h11); rf_pend.push_back(8'h22); alu_pend.push_back(16'h5566);
    wait_idle("t3");
    check_log("t3", lb, '{8'h11, 8'h66, 8'h55, 8'h22});

    // Stall on the high byte for three cycles
    lb = wlog.size(); wb = winc_cnt;
    step(); alu_pend.push_back(16'hBEEF);
    @(posedge wclk); @(posedge wclk); step();
    wfull = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    check("t4_wdata_stalled", 32'(wdata), 32'h0000_00BE);
    check("t4_winc_stalled",  32'(winc),  32'd1);
    #1;
    wfull = 1'b0;
    wait_idle("t4");
    check("t4_winc_cycles", 32'(winc_cnt - wb), 32'd5);
    check_log("t4", lb, '{8'hEF, 8'hBE});

    // Reset during SEND_HI drops the high byte
    lb = wlog.size();
    step(); alu_pend.push_back(16'hCAFE);
    @(posedge wclk); @(posedge wclk); step();
    wrst_n = 1'b0;
    #1;
    check("t5_winc_in_reset", 32'(winc), 32'd0);
    check("t5_busy_in_reset", 32'(busy), 32'd0);
    step();
    wrst_n = 1'b1;
    step(); rf_pend.push_back(8'h3C);
    wait_idle("t5");
    check_log("t5", lb, '{8'hFE, 8'h3C});

    // last_grant returns to ALU on reset even after an RF grant
    pulse_reset();
    lb = wlog.size();
    step(); rf_pend.push_back(8'h01); alu_pend.push_back(16'h0203);
    wait_idle("t5b");
    check_log("t5b", lb, '{8'h01, 8'h03, 8'h02});

    // FIFO full with RF requests pending
    lb = wlog.size(); rb = rf_rdy_cnt;
    step();
    wfull = 1'b1;
    rf_pend.push_back(8'h99); rf_pend.push_back(8'h98);
    repeat (5) @(posedge wclk);
    #1;
    check("t6_rf_ready_while_full", 32'(rf_rdy_cnt - rb), 32'd1);
    check("t6_no_writes_while_full", 32'(wlog.size() - lb), 32'd0);
    check("t6_wdata_held", 32'(wdata), 32'h0000_0099);
    #1;
    wfull = 1'b0;
    wait_idle("t6");
    check("t6_rf_ready_total", 32'(rf_rdy_cnt - rb), 32'd2);
    check_log("t6", lb, '{8'h99, 8'h98});

    repeat (3) @(posedge wclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Write-side controller for the async TX FIFO; shares the single FIFO write port between the register-file read path (1 byte) and the ALU result path (2 bytes, low byte first).
- Arbitrates round-robin and captures the winning request into a holding register.
- Sequences one or two FIFO writes, stalling on `wfull`.
- Sits in the write clock domain, directly in front of the FIFO write port (`winc`, `wdata`, `wfull`).

## Interface
- `DATA_WIDTH`, 8, FIFO word width; the ALU result is 2*DATA_WIDTH.
- `wclk`  in  1  write-domain clock; all logic on rising edge.
- `wrst_n`  in  1  asynchronous, active-low reset.
- `rf_valid`  in  1  register-file byte request.
- `rf_data`  in  DATA_WIDTH  register-file byte.
- `rf_ready`  out  1  RF request accepted this cycle.
- `alu_valid`  in  1  ALU result request.
- `alu_data`  in  2*DATA_WIDTH  ALU result; low byte is sent first.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `wfull`  in  1  FIFO full flag (registered, write domain).
- `winc`  out  1  FIFO write request.
- `wdata`  out  DATA_WIDTH  FIFO write data.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, SEND_LO, SEND_HI.
- **IDLE**
  - If either valid is high, grant one requester.
  - Assert its ready combinationally in the same cycle.
  - Load `hold[2*DATA_WIDTH-1:0]` and `hold_two`:
    - RF: `hold = {0, rf_data}`, `hold_two = 0`.
    - ALU: `hold = alu_data`, `hold_two = 1`.
  - Go to SEND_LO.
- **Arbitration**
  - Only one valid high: that requester wins.
  - Both high: the requester not named in `last_grant` wins.
  - `last_grant` updates on every grant.
  - `last_grant` resets to ALU, so the first tie goes to RF.
- **SEND_LO**
  - `winc = 1`, `wdata = hold[DATA_WIDTH-1:0]`.
  - A beat is accepted when `winc & ~wfull`.
  - On acceptance: go to SEND_HI if `hold_two`, else IDLE.
  - Otherwise hold state, data and `winc`.
- **SEND_HI**
  - `winc = 1`, `wdata = hold[2*DATA_WIDTH-1:DATA_WIDTH]`.
  - On acceptance go to IDLE.
- **Output decode**
  - `winc`, `wdata` and `busy` are decoded from state and `hold` only.
  - `wfull` does not gate `winc`; the FIFO masks it internally, so the arbiter and the FIFO agree on which beats are written.
- **Requester handshake**
  - Ready is never asserted outside IDLE.
  - Requesters hold valid and data until ready.
  - Data is sampled only in the ready cycle.

## Timing
- Reset values:
  - state = IDLE; `winc`, `busy`, `rf_ready`, `alu_ready` = 0.
  - `wdata` = 0; `hold` = 0; `hold_two` = 0; `last_grant` = ALU.
- Acceptance to first `winc`: 1 cycle.
- RF transfer with no stall: 2 cycles (IDLE, SEND_LO).
- ALU transfer with no stall: 3 cycles.
- Back-to-back requests: exactly one IDLE cycle between the last accepted beat and the next `winc`.
- `wfull` high: each stalled cycle adds one cycle; `wdata` is stable throughout.
- `wfull` rising in the cycle after the low byte: the high byte stalls in SEND_HI and is never dropped or duplicated.
- Reset asserted mid-transfer: state is forced to IDLE immediately (asynchronous).
  - `winc` drops at once; the held byte is discarded.
  - After release, the next grant is a fresh tie-break with `last_grant` = ALU.
- A ready cycle with valid deasserted cannot occur; ready requires valid.

## Structure
- Shared package:
  - State encoding (2-bit localparams IDLE=0, SEND_LO=1, SEND_HI=2).
  - Requester ID constants (REQ_RF=0, REQ_ALU=1).
- One natural sub-module: `rr_arb2`, a 2-input round-robin grant with a `last_grant` register and an `update` enable.
- FSM and holding register stay in the top.

## Test plan
1. Reset, then `rf_valid` with `rf_data`=0xA5, `wfull`=0 -> `rf_ready` for 1 cycle; next cycle a single `winc` with `wdata`=0xA5; `busy` falls after it.
2. `alu_data`=0x1234, no stall -> `winc` on 2 consecutive cycles with `wdata` 0x34 then 0x12; `alu_ready` for 1 cycle only.
3. Both valid from reset, held -> grants alternate RF, ALU, RF; FIFO sees bytes RF, lo, hi, RF; one IDLE gap between transfers.
4. ALU 0xBEEF, `wfull` high for 3 cycles from the SEND_HI cycle -> 0xEF written once; `wdata` holds 0xBE with `winc` high for 3 cycles; 0xBE written once after `wfull` drops.
5. `wrst_n` pulsed low during SEND_HI of 0xCAFE -> `winc` = 0 immediately; no 0xCA beat after release; next RF request is served normally.
6. `wfull` held high with `rf_valid` pending -> RF captured, `winc` held, no further ready until `wfull` falls and the beat is accepted.
